// File: rtl/led_pwm_ctrl_pkg.sv
// rtl/led_pwm_ctrl_pkg.sv - shared types and constants for the LED PWM peripheral
// Contents:
//   fade_state_t      fade engine states (ST_STEADY, ST_FADE)
//   CTRL_*            bit positions inside the control register
//   DEF_PORT_*        default KCPSM6 port addresses
`timescale 1ns/1ps
package led_pwm_ctrl_pkg;

   typedef enum logic {
      ST_STEADY = 1'b0,
      ST_FADE   = 1'b1
   } fade_state_t;

   localparam int CTRL_BLINK   = 0;
   localparam int CTRL_FADE    = 1;
   localparam int CTRL_RATE_LO = 2;
   localparam int CTRL_RATE_HI = 3;

   localparam logic [7:0] DEF_PORT_PATTERN = 8'h02;
   localparam logic [7:0] DEF_PORT_DUTY    = 8'h03;
   localparam logic [7:0] DEF_PORT_CTRL    = 8'h04;

endpackage

// File: rtl/led_pwm_gen.sv
// rtl/led_pwm_gen.sv - prescaled 8-bit PWM brightness generator
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   level[7:0]   brightness; 0 is always off, 8'hFF is always on
//   pwm_on       high while the free-running PWM counter is below level
`timescale 1ns/1ps
module led_pwm_gen #(
   parameter int PWM_PRESCALE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] level,
   output logic       pwm_on
);

   localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

   logic [PW-1:0] pre_cnt;
   logic [7:0]    pwm_cnt;
   logic          pre_wrap;

   assign pre_wrap = (32'(pre_cnt) == 32'(PWM_PRESCALE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else if (pre_wrap) begin
         pre_cnt <= '0;
         pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   // 8'hFF is forced fully on; a plain compare would leave one dark step in 256
   always_comb begin
      pwm_on = 1'b0;
      if (level == 8'h00)
         pwm_on = 1'b0;
      else if (level == 8'hFF)
         pwm_on = 1'b1;
      else
         pwm_on = (pwm_cnt < level);
   end

endmodule

// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - KCPSM6 output-port LED driver with PWM, blink and fade
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   port_id, out_port       processor port address and write data
//   write_strobe            OUTPUT strobe, full 8-bit address decode
//   k_write_strobe          OUTPUTK strobe, low-nibble address decode
//   read_strobe             unused, reads have no side effects
//   rd_data[7:0]            combinational readback, 0 when port unmatched
//   led[7:0]                registered LED drive
//   busy                    high while a fade is in progress
`timescale 1ns/1ps
module led_pwm_ctrl
   import led_pwm_ctrl_pkg::*;
#(
   parameter logic [7:0] PORT_PATTERN = DEF_PORT_PATTERN,
   parameter logic [7:0] PORT_DUTY    = DEF_PORT_DUTY,
   parameter logic [7:0] PORT_CTRL    = DEF_PORT_CTRL,
   parameter int         PWM_PRESCALE = 4,
   parameter int         BLINK_BASE   = 12500000,
   parameter int         FADE_DIV     = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       k_write_strobe,
   input  logic       read_strobe,
   output logic [7:0] rd_data,
   output logic [7:0] led,
   output logic       busy
);

   localparam int BW = $clog2(BLINK_BASE << 3);
   localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

   logic [7:0]    pattern;
   logic [7:0]    duty;
   logic [3:0]    ctrl;
   logic [7:0]    cur_level;
   fade_state_t   state;
   logic [FW-1:0] fade_cnt;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic          pwm_on;
   logic          gate_b;
   logic          k_only;
   logic          wr_pat, wr_duty, wr_ctrl;
   logic          fade_en;
   logic          fade_tick;
   logic [7:0]    target;
   logic [7:0]    step;
   logic [31:0]   blink_top;
   logic          unused_ok;

   assign unused_ok = read_strobe;

   // OUTPUT wins over OUTPUTK when both strobes fire together
   assign k_only  = k_write_strobe & ~write_strobe;
   assign wr_pat  = (write_strobe & (port_id == PORT_PATTERN)) |
                    (k_only & (port_id[3:0] == PORT_PATTERN[3:0]));
   assign wr_duty = (write_strobe & (port_id == PORT_DUTY)) |
                    (k_only & (port_id[3:0] == PORT_DUTY[3:0]));
   assign wr_ctrl = (write_strobe & (port_id == PORT_CTRL)) |
                    (k_only & (port_id[3:0] == PORT_CTRL[3:0]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern <= 8'h00;
         duty    <= 8'hFF;
         ctrl    <= 4'h0;
      end else begin
         if (wr_pat)  pattern <= out_port;
         if (wr_duty) duty    <= out_port;
         if (wr_ctrl) ctrl    <= out_port[3:0];
      end
   end

   always_comb begin
      rd_data = 8'h00;
      if (port_id == PORT_PATTERN)
         rd_data = pattern;
      else if (port_id == PORT_DUTY)
         rd_data = duty;
      else if (port_id == PORT_CTRL)
         rd_data = {4'b0000, ctrl};
   end

   // Blink: half-period doubles with each rate_sel step
   assign blink_top = (32'(BLINK_BASE) << ctrl[CTRL_RATE_HI:CTRL_RATE_LO]) - 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (wr_ctrl) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (32'(blink_cnt) == blink_top) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + BW'(1);
      end
   end

   assign gate_b = ctrl[CTRL_BLINK] ? blink_phase : 1'b1;

   // Fade engine: target follows a duty write in the same cycle so a
   // retarget mid-fade steps toward the new value without restarting
   assign fade_en   = ctrl[CTRL_FADE];
   assign target    = wr_duty ? out_port : duty;
   assign fade_tick = (32'(fade_cnt) == 32'(FADE_DIV - 1));
   assign step      = (cur_level < target) ? cur_level + 8'd1 : cur_level - 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_STEADY;
         cur_level <= 8'hFF;
         fade_cnt  <= '0;
         busy      <= 1'b0;
      end else if (wr_duty && !fade_en) begin
         cur_level <= out_port;
         state     <= ST_STEADY;
         busy      <= 1'b0;
      end else if (state == ST_STEADY) begin
         if (wr_duty && (out_port != cur_level)) begin
            state    <= ST_FADE;
            busy     <= 1'b1;
            fade_cnt <= '0;
         end
      end else begin
         if (!fade_en) begin
            cur_level <= duty;
            state     <= ST_STEADY;
            busy      <= 1'b0;
         end else if (target == cur_level) begin
            state <= ST_STEADY;
            busy  <= 1'b0;
         end else if (fade_tick) begin
            fade_cnt  <= '0;
            cur_level <= step;
            if (step == target) begin
               state <= ST_STEADY;
               busy  <= 1'b0;
            end
         end else begin
            fade_cnt <= fade_cnt + FW'(1);
         end
      end
   end

   led_pwm_gen #(
      .PWM_PRESCALE (PWM_PRESCALE)
   ) u_pwm (
      .clk    (clk),
      .rst_n  (rst_n),
      .level  (cur_level),
      .pwm_on (pwm_on)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         led <= 8'h00;
      else
         led <= pattern & {8{pwm_on & gate_b}};
   end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb/tb_led_pwm_ctrl.sv - directed self-checking bench for led_pwm_ctrl
`timescale 1ns/1ps
module tb_led_pwm_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic       k_write_strobe;
   logic       read_strobe;
   logic [7:0] rd_data;
   logic [7:0] led;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int hi_cnt;
   int bad_cnt;

   logic [7:0] lv_exp [0:8];
   logic       bz_exp [0:8];

   always #5 clk = ~clk;

   led_pwm_ctrl #(
      .PORT_PATTERN (8'h02),
      .PORT_DUTY    (8'h03),
      .PORT_CTRL    (8'h04),
      .PWM_PRESCALE (1),
      .BLINK_BASE   (8),
      .FADE_DIV     (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .port_id        (port_id),
      .out_port       (out_port),
      .write_strobe   (write_strobe),
      .k_write_strobe (k_write_strobe),
      .read_strobe    (read_strobe),
      .rd_data        (rd_data),
      .led            (led),
      .busy           (busy)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; the register loads on the next posedge and
   // the task returns at the following negedge.
   task automatic wr(input logic [7:0] addr, input logic [7:0] data, input logic use_k);
      port_id        = addr;
      out_port       = data;
      write_strobe   = ~use_k;
      k_write_strobe = use_k;
      @(negedge clk);
      write_strobe   = 1'b0;
      k_write_strobe = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      port_id = addr;
      #1;
      check(tag, rd_data, exp);
   endtask

   initial begin
      rst_n          = 1'b0;
      port_id        = 8'h00;
      out_port       = 8'h00;
      write_strobe   = 1'b0;
      k_write_strobe = 1'b0;
      read_strobe    = 1'b0;
      lv_exp = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFC, 8'hFC, 8'hFB};
      bz_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      check("rst_led", led, 8'h00);
      check("rst_busy", {7'b0, busy}, 8'h00);
      check("rst_level", dut.cur_level, 8'hFF);
      rd_check("rst_duty", 8'h03, 8'hFF);
      rd_check("rst_pat", 8'h02, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Pattern write, two-cycle latency to the pin
      wr(8'h02, 8'hA5, 1'b0);
      check("pat_lat0", led, 8'h00);
      @(negedge clk);
      check("pat_led", led, 8'hA5);
      rd_check("pat_rd", 8'h02, 8'hA5);
      @(negedge clk);

      // Duty 8'h40: 64 of every 256 cycles on
      wr(8'h03, 8'h40, 1'b0);
      @(negedge clk);
      hi_cnt = 0;
      bad_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (led == 8'hA5) hi_cnt++;
         else if (led != 8'h00) bad_cnt++;
      end
      check("duty40_on", 8'(hi_cnt), 8'd64);
      check("duty40_bad", 8'(bad_cnt), 8'd0);

      // Duty 0: always dark
      wr(8'h03, 8'h00, 1'b0);
      @(negedge clk);
      hi_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (led != 8'h00) hi_cnt++;
      end
      check("duty00_on", 8'(hi_cnt), 8'd0);

      // Duty FF: always the pattern
      wr(8'h03, 8'hFF, 1'b0);
      @(negedge clk);
      hi_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (led == 8'hA5) hi_cnt++;
      end
      check("dutyFF_on", 8'(hi_cnt[7:0]), 8'd0);
      check("dutyFF_hi", 8'(hi_cnt >> 8), 8'd1);

      // OUTPUTK nibble decode versus OUTPUT full decode
      wr(8'hF3, 8'h80, 1'b1);
      rd_check("k_duty", 8'h03, 8'h80);
      check("k_level", dut.cur_level, 8'h80);
      @(negedge clk);
      wr(8'hF3, 8'h11, 1'b0);
      rd_check("full_ign", 8'h03, 8'h80);
      rd_check("unmatched", 8'hF3, 8'h00);
      @(negedge clk);

      // Blink at rate 1: 16 clks visible, 16 dark
      wr(8'h03, 8'hFF, 1'b0);
      wr(8'h04, 8'h05, 1'b0);
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         check("blink", led, (k <= 16) ? 8'hA5 : 8'h00);
      end
      rd_check("ctrl_rd", 8'h04, 8'h05);
      @(negedge clk);
      wr(8'h04, 8'hF0, 1'b0);
      rd_check("ctrl_rsvd", 8'h04, 8'h00);
      @(negedge clk);

      // Fade FF -> FB
      wr(8'h04, 8'h02, 1'b0);
      wr(8'h03, 8'hFB, 1'b0);
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) @(negedge clk);
         check("fade_lvl", dut.cur_level, lv_exp[k]);
         check("fade_busy", {7'b0, busy}, {7'b0, bz_exp[k]});
      end

      // Fade FF -> FB, retarget to FD at level FC
      wr(8'h04, 8'h00, 1'b0);
      wr(8'h03, 8'hFF, 1'b0);
      check("snap_lvl", dut.cur_level, 8'hFF);
      wr(8'h04, 8'h02, 1'b0);
      wr(8'h03, 8'hFB, 1'b0);
      repeat (6) @(negedge clk);
      check("rt_pre", dut.cur_level, 8'hFC);
      wr(8'h03, 8'hFD, 1'b0);
      check("rt_lvl0", dut.cur_level, 8'hFC);
      check("rt_busy0", {7'b0, busy}, 8'h01);
      @(negedge clk);
      check("rt_lvl1", dut.cur_level, 8'hFD);
      check("rt_busy1", {7'b0, busy}, 8'h00);

      // Asynchronous reset mid-fade
      wr(8'h03, 8'hF0, 1'b0);
      repeat (2) @(negedge clk);
      check("ar_busy_pre", {7'b0, busy}, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_led", led, 8'h00);
      check("ar_busy", {7'b0, busy}, 8'h00);
      check("ar_level", dut.cur_level, 8'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd_check("ar_duty", 8'h03, 8'hFF);
      rd_check("ar_ctrl", 8'h04, 8'h00);
      check("ar_level2", dut.cur_level, 8'hFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
